// File: rtl/gpio_bank_regs.sv
// gpio_bank_regs: parametrised GPIO register bank with pin drive, input sync and W1C edge interrupts
module gpio_bank_regs #(
  parameter int NumPins = 72,
  parameter int BusWidth = 32,
  parameter int AddrWidth = 16,
  parameter logic [AddrWidth-1:0] BaseAddr = 'h2000
) (
  input  logic                 reg_clk,
  input  logic                 reset_in,
  input  logic                 chip_sel,
  input  logic                 write_reg,
  input  logic                 read_reg,
  input  logic [AddrWidth-1:0] busaddress,
  input  logic [BusWidth-1:0]  busdata_in,
  output logic [BusWidth-1:0]  busdata_out,
  output logic                 read_valid,
  input  logic [NumPins-1:0]   gpio_in,
  output logic [NumPins-1:0]   gpio_out,
  output logic [NumPins-1:0]   gpio_oe,
  output logic                 irq
);
  localparam int NumWords = (NumPins + 31) / 32;
  localparam int W = NumWords * 32;
  localparam logic [W:0] One = 1;
  localparam logic [W-1:0] Valid = W'((One << NumPins) - One);
  logic [W-1:0] ddr, odrain, dout, rise_en, fall_en, status;
  logic [W-1:0] s2w, pw, ev, wm, wv, w1c, src;
  logic [NumPins-1:0] s1, s2, p;
  logic [AddrWidth-1:0] off;
  logic [2:0] sel;
  logic [3:0] k;
  logic hit, we, re, unused_addr;
  logic [BusWidth-1:0] rdata;
  assign off = busaddress - BaseAddr;
  assign sel = off[8:6];
  assign k = off[5:2];
  assign unused_addr = ^off[1:0];
  assign hit = busaddress >= BaseAddr && off[AddrWidth-1:9] == '0 && 32'(k) < NumWords;
  assign we = chip_sel & write_reg & hit;
  assign re = chip_sel & read_reg;
  assign wm = (W'(32'hFFFF_FFFF) << {k, 5'b0}) & Valid;
  assign wv = (W'(busdata_in) << {k, 5'b0}) & wm;
  assign w1c = (we && sel == 3'd6) ? wv : '0;
  assign s2w = W'(s2);
  assign pw = W'(p);
  assign ev = (s2w & ~pw & rise_en) | (~s2w & pw & fall_en);
  always_comb begin
    src = sel == 3'd0 ? ddr :
          sel == 3'd1 ? odrain :
          sel == 3'd2 ? dout :
          sel == 3'd3 ? s2w :
          sel == 3'd4 ? rise_en :
          sel == 3'd5 ? fall_en :
          sel == 3'd6 ? status : '0;
    rdata = hit ? BusWidth'(src >> {k, 5'b0}) : '0;
  end
  always_ff @(posedge reg_clk) begin
    if (reset_in) begin
      {ddr, odrain, dout, rise_en, fall_en, status} <= '0;
      {s1, s2, p} <= '0;
      {gpio_out, gpio_oe} <= '0;
      busdata_out <= '0;
      read_valid <= 1'b0;
      irq <= 1'b0;
    end else begin
      ddr <= (we && sel == 3'd0) ? (ddr & ~wm) | wv : ddr;
      odrain <= (we && sel == 3'd1) ? (odrain & ~wm) | wv : odrain;
      dout <= (we && sel == 3'd2) ? (dout & ~wm) | wv : dout;
      rise_en <= (we && sel == 3'd4) ? (rise_en & ~wm) | wv : rise_en;
      fall_en <= (we && sel == 3'd5) ? (fall_en & ~wm) | wv : fall_en;
      status <= ev | (status & ~w1c);
      s1 <= gpio_in;
      s2 <= s1;
      p <= s2;
      gpio_out <= dout[NumPins-1:0] & ~odrain[NumPins-1:0];
      gpio_oe <= ddr[NumPins-1:0] & (~odrain[NumPins-1:0] | ~dout[NumPins-1:0]);
      read_valid <= re;
      busdata_out <= re ? rdata : busdata_out;
      irq <= |status;
    end
  end
endmodule

// File: tb/tb_gpio_bank_regs.sv
// tb_gpio_bank_regs: directed self-checking bench for gpio_bank_regs
module tb_gpio_bank_regs;
  logic reg_clk = 1'b0;
  logic reset_in, chip_sel, write_reg, read_reg, read_valid, irq;
  logic [15:0] busaddress;
  logic [31:0] busdata_in, busdata_out;
  logic [71:0] gpio_in, gpio_out, gpio_oe;
  int tests = 0;
  int fails = 0;
  always #5 reg_clk = ~reg_clk;
  gpio_bank_regs dut (
    .reg_clk(reg_clk),
    .reset_in(reset_in),
    .chip_sel(chip_sel),
    .write_reg(write_reg),
    .read_reg(read_reg),
    .busaddress(busaddress),
    .busdata_in(busdata_in),
    .busdata_out(busdata_out),
    .read_valid(read_valid),
    .gpio_in(gpio_in),
    .gpio_out(gpio_out),
    .gpio_oe(gpio_oe),
    .irq(irq)
  );
  task automatic tick(input int n = 1);
    repeat (n) @(posedge reg_clk);
    #1;
  endtask
  task automatic chk(input logic [31:0] obs, input logic [31:0] exp, input string tag);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic wr(input logic [15:0] a, input logic [31:0] d);
    chip_sel = 1'b1;
    write_reg = 1'b1;
    busaddress = a;
    busdata_in = d;
    tick();
    chip_sel = 1'b0;
    write_reg = 1'b0;
  endtask
  task automatic rd(input logic [15:0] a, input logic [31:0] exp, input string tag);
    chip_sel = 1'b1;
    read_reg = 1'b1;
    busaddress = a;
    tick();
    chip_sel = 1'b0;
    read_reg = 1'b0;
    chk(32'(read_valid), 32'd1, {tag, "_valid"});
    chk(busdata_out, exp, tag);
    tick();
    chk(32'(read_valid), 32'd0, {tag, "_valid_low"});
  endtask
  initial begin
    reset_in = 1'b1;
    chip_sel = 1'b0;
    write_reg = 1'b0;
    read_reg = 1'b0;
    busaddress = '0;
    busdata_in = '0;
    gpio_in = '0;
    tick(3);
    chk(busdata_out, 32'd0, "rst_busdata");
    chk(32'(read_valid), 32'd0, "rst_valid");
    chk(gpio_oe[31:0], 32'd0, "rst_oe");
    chk(gpio_out[31:0], 32'd0, "rst_out");
    chk(32'(irq), 32'd0, "rst_irq");
    reset_in = 1'b0;
    tick();
    for (int s = 0; s < 7; s++)
      for (int k = 0; k < 3; k++)
        rd(16'h2000 + 16'(s * 64 + k * 4), 32'd0, "map_zero");
    chk(32'(irq), 32'd0, "idle_irq");
    wr(16'h2008, 32'hFFFF_FFFF);
    rd(16'h2008, 32'h0000_00FF, "ddr2_mask");
    tick(2);
    chk(busdata_out, 32'h0000_00FF, "busdata_hold");
    chk(gpio_oe[71:64], 32'h0000_00FF, "oe_hi_pins");
    wr(16'h200C, 32'hFFFF_FFFF);
    rd(16'h200C, 32'd0, "k_out_of_range");
    wr(16'h2200, 32'hFFFF_FFFF);
    wr(16'h1FFC, 32'hFFFF_FFFF);
    wr(16'h21C0, 32'hFFFF_FFFF);
    rd(16'h2000, 32'd0, "outside_window_write");
    rd(16'h21C0, 32'd0, "unmapped_read");
    rd(16'h2200, 32'd0, "past_window_read");
    write_reg = 1'b1;
    busaddress = 16'h2000;
    busdata_in = 32'hFFFF_FFFF;
    tick();
    write_reg = 1'b0;
    rd(16'h2000, 32'd0, "no_chip_sel_write");
    read_reg = 1'b1;
    tick();
    read_reg = 1'b0;
    chk(32'(read_valid), 32'd0, "no_chip_sel_read");
    gpio_in[31:0] = 32'hA5A5_0F0F;
    gpio_in[71:64] = 8'hC3;
    tick(3);
    rd(16'h20C0, 32'hA5A5_0F0F, "in0");
    rd(16'h20C8, 32'h0000_00C3, "in2");
    wr(16'h20C0, 32'h0000_1234);
    rd(16'h20C0, 32'hA5A5_0F0F, "in0_ro");
    gpio_in = '0;
    tick(4);
    wr(16'h2040, 32'd1);
    wr(16'h2000, 32'd1);
    tick();
    chk(32'(gpio_oe[0]), 32'd1, "od_low_oe");
    chk(32'(gpio_out[0]), 32'd0, "od_low_out");
    wr(16'h2080, 32'd1);
    chk(32'(gpio_oe[0]), 32'd1, "od_oe_registered");
    tick();
    chk(32'(gpio_oe[0]), 32'd0, "od_high_release");
    chk(32'(gpio_out[0]), 32'd0, "od_high_out");
    wr(16'h2040, 32'd0);
    tick();
    chk(32'(gpio_oe[0]), 32'd1, "pp_high_oe");
    chk(32'(gpio_out[0]), 32'd1, "pp_high_out");
    wr(16'h2000, 32'd0);
    wr(16'h2080, 32'd0);
    chip_sel = 1'b1;
    read_reg = 1'b1;
    write_reg = 1'b1;
    busaddress = 16'h2080;
    busdata_in = 32'd5;
    tick();
    chip_sel = 1'b0;
    read_reg = 1'b0;
    write_reg = 1'b0;
    chk(32'(read_valid), 32'd1, "rw_same_valid");
    chk(busdata_out, 32'd0, "rw_same_old");
    rd(16'h2080, 32'd5, "rw_same_new");
    wr(16'h2080, 32'd0);
    wr(16'h2088, 32'hFFFF_FFFF);
    tick();
    chk(gpio_out[71:64], 32'h0000_00FF, "out2_drive");
    wr(16'h2088, 32'd0);
    wr(16'h2100, 32'h10);
    gpio_in[4] = 1'b1;
    tick(2);
    chip_sel = 1'b1;
    read_reg = 1'b1;
    busaddress = 16'h2180;
    tick();
    chk(busdata_out, 32'd0, "status_t2");
    chk(32'(irq), 32'd0, "irq_t3");
    tick();
    chip_sel = 1'b0;
    read_reg = 1'b0;
    chk(32'(read_valid), 32'd1, "b2b_valid");
    chk(busdata_out, 32'h10, "status_t3");
    chk(32'(irq), 32'd1, "irq_t4");
    gpio_in[4] = 1'b0;
    tick(5);
    rd(16'h2180, 32'h10, "no_fall_event");
    wr(16'h2180, 32'd0);
    rd(16'h2180, 32'h10, "w1c_zero_bits");
    wr(16'h2100, 32'd0);
    rd(16'h2180, 32'h10, "sticky_after_disable");
    wr(16'h2180, 32'h10);
    chk(32'(irq), 32'd1, "irq_w1c_plus1");
    tick();
    chk(32'(irq), 32'd0, "irq_w1c_plus2");
    rd(16'h2180, 32'd0, "status_cleared");
    gpio_in[67] = 1'b1;
    tick(4);
    wr(16'h2148, 32'h8);
    gpio_in[67] = 1'b0;
    tick(5);
    rd(16'h2188, 32'h8, "fall_pin67");
    chk(32'(irq), 32'd1, "irq_fall");
    wr(16'h2188, 32'h8);
    tick(2);
    chk(32'(irq), 32'd0, "irq_fall_clear");
    wr(16'h2148, 32'd0);
    wr(16'h2108, 32'hFFFF_FFFF);
    rd(16'h2108, 32'h0000_00FF, "rise_en2_mask");
    wr(16'h2108, 32'd0);
    wr(16'h2100, 32'h10);
    gpio_in[4] = 1'b1;
    tick(5);
    gpio_in[4] = 1'b0;
    tick(5);
    rd(16'h2180, 32'h10, "pre_collision");
    gpio_in[4] = 1'b1;
    tick(2);
    wr(16'h2180, 32'h10);
    rd(16'h2180, 32'h10, "set_wins_over_w1c");
    chk(32'(irq), 32'd1, "irq_before_reset");
    chip_sel = 1'b1;
    read_reg = 1'b1;
    busaddress = 16'h2008;
    reset_in = 1'b1;
    tick();
    chip_sel = 1'b0;
    read_reg = 1'b0;
    chk(32'(read_valid), 32'd0, "mid_read_reset_valid");
    chk(busdata_out, 32'd0, "mid_read_reset_data");
    chk(gpio_oe[71:64], 32'd0, "mid_read_reset_oe");
    chk(gpio_out[31:0], 32'd0, "mid_read_reset_out");
    chk(32'(irq), 32'd0, "mid_read_reset_irq");
    reset_in = 1'b0;
    tick();
    chk(32'(read_valid), 32'd0, "post_reset_valid");
    rd(16'h2008, 32'd0, "post_reset_ddr2");
    rd(16'h2180, 32'd0, "post_reset_status");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
